// File: rtl/conv_norm_stage.sv
// Multi-channel post-convolution normalisation: (x - avg) * std in fixed point with
// saturation and optional ReLU. Parameters load serially; the block sequences frames itself.
module conv_norm_stage #(
  parameter int DW   = 16,
  parameter int CH   = 4,
  parameter int FRAC = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [8:0]       image_size,
  input  logic [1:0]       mode,
  input  logic             pi_param_valid,
  input  logic [DW-1:0]    pi_param,
  input  logic             pi_data_valid,
  input  logic [CH*DW-1:0] pi_data,
  output logic [CH*DW-1:0] po_data,
  output logic             po_data_valid,
  output logic             frame_done,
  output logic             params_ready,
  output logic             busy
);
  localparam int NP = 2 * CH;
  localparam int IW = $clog2(NP + 1);
  localparam int CW = 18;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_PARAM, WAIT, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ready_q, ready_d;
  logic [CW-1:0] cnt_q, cnt_d, tgt_q, tgt_d, tgt_sq;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          accept, last_in;
  // Rank 0 holds the captured sample, ranks 1..3 the stage results; mode/last ride alongside.
  logic [3:0]      v_q, v_d, l_q, l_d;
  logic [2:0][1:0] m_q, m_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    accept  = 1'b0;
    last_in = 1'b0;
    tgt_sq  = CW'(image_size) * CW'(image_size);
    case (state_q)
      IDLE, WAIT: begin
        if (pi_param_valid) begin
          wr_en   = 1'b1;
          wr_idx  = '0;
          idx_d   = IW'(1);
          ready_d = 1'b0;
          state_d = LOAD_PARAM;
        end else if (state_q == WAIT && pi_data_valid) begin
          accept  = 1'b1;
          cnt_d   = CW'(1);
          tgt_d   = (image_size <= 9'd1) ? CW'(1) : tgt_sq;
          last_in = (tgt_d == CW'(1));
          state_d = last_in ? DONE : RUN;
        end
      end
      LOAD_PARAM: begin
        if (pi_param_valid && idx_q < IW'(NP)) begin
          wr_en = 1'b1;
          idx_d = idx_q + IW'(1);
          if (idx_q == IW'(NP - 1)) ready_d = 1'b1;
        end
        if (ready_q && !pi_param_valid) state_d = WAIT;
      end
      RUN: begin
        if (pi_data_valid) begin
          accept  = 1'b1;
          cnt_d   = cnt_q + CW'(1);
          last_in = (cnt_d == tgt_q);
          if (last_in) state_d = DONE;
        end
      end
      DONE:    state_d = WAIT;
      default: state_d = IDLE;
    endcase
    v_d = {v_q[2:0], accept};
    l_d = {l_q[2:0], last_in};
    m_d = {m_q[1:0], mode};
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      v_q     <= '0;
      l_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      v_q     <= v_d;
      l_q     <= l_d;
      m_q     <= m_d;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic signed [DW-1:0]   avg_q, avg_d, std_q, std_d;
    logic signed [DW-1:0]   x0_q, x0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        [DW:0]     diff;
    logic signed [2*DW-1:0] prod, shifted;
    logic        [DW:0]     hi;

    always_comb begin
      avg_d = avg_q;
      std_d = std_q;
      if (wr_en && wr_idx == IW'(2 * gi))     avg_d = pi_param;
      if (wr_en && wr_idx == IW'(2 * gi + 1)) std_d = pi_param;
      x0_d = accept ? pi_data[gi*DW +: DW] : x0_q;

      diff = {x0_q[DW-1], x0_q} - {avg_q[DW-1], avg_q};
      if (m_q[0] == 2'd0)              s1_d = x0_q;
      else if (diff[DW] != diff[DW-1]) s1_d = diff[DW] ? SMIN : SMAX;
      else                             s1_d = diff[DW-1:0];

      // Floor shift, then the kept bits plus sign must agree or the result saturates.
      prod    = $signed({{DW{s1_q[DW-1]}}, s1_q}) * $signed({{DW{std_q[DW-1]}}, std_q});
      shifted = prod >>> FRAC;
      hi      = shifted[2*DW-1:DW-1];
      if (m_q[1] == 2'd0)       s2_d = s1_q;
      else if (&hi || ~|hi)     s2_d = shifted[DW-1:0];
      else                      s2_d = shifted[2*DW-1] ? SMIN : SMAX;

      s3_d = (m_q[2] == 2'd2 && s2_q[DW-1]) ? '0 : s2_q;
    end

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        avg_q <= '0;
        std_q <= '0;
        x0_q  <= '0;
        s1_q  <= '0;
        s2_q  <= '0;
        s3_q  <= '0;
      end else begin
        avg_q <= avg_d;
        std_q <= std_d;
        x0_q  <= x0_d;
        s1_q  <= s1_d;
        s2_q  <= s2_d;
        s3_q  <= s3_d;
      end
    end

    assign po_data[gi*DW +: DW] = s3_q;
  end

  assign po_data_valid = v_q[3];
  assign frame_done    = v_q[3] & l_q[3];
  assign params_ready  = ready_q;
  assign busy          = (state_q == RUN) | (|v_q);
endmodule

// File: tb/tb_conv_norm_stage.sv
// Directed bench for conv_norm_stage: a reference model fills a scoreboard at
// acceptance; a negedge monitor checks data, 3-cycle latency and frame_done.
module tb_conv_norm_stage;
  localparam int DW = 16;
  localparam int CH = 4;
  localparam int FRAC = 8;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [8:0]       image_size = '0;
  logic [1:0]       mode = '0;
  logic             pi_param_valid = 1'b0;
  logic [DW-1:0]    pi_param = '0;
  logic             pi_data_valid = 1'b0;
  logic [CH*DW-1:0] pi_data = '0;
  logic [CH*DW-1:0] po_data;
  logic             po_data_valid, frame_done, params_ready, busy;

  conv_norm_stage #(.DW(DW), .CH(CH), .FRAC(FRAC)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .image_size(image_size), .mode(mode),
    .pi_param_valid(pi_param_valid), .pi_param(pi_param),
    .pi_data_valid(pi_data_valid), .pi_data(pi_data),
    .po_data(po_data), .po_data_valid(po_data_valid), .frame_done(frame_done),
    .params_ready(params_ready), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [CH*DW-1:0] data;
    int               due;
    logic             last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, failures = 0, fd_count = 0;
  int avg_m[CH], std_m[CH], xv[CH];
  int fx[16][CH];
  int fm[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_norm(input int x, input int a, input int s, input int m);
    longint d, p;
    if (m == 0) return DW'(x);
    d = longint'(x) - longint'(a);
    if (d > 32767) d = 32767;
    if (d < -32768) d = -32768;
    p = (d * longint'(s)) >>> FRAC;
    if (p > 32767) p = 32767;
    if (p < -32768) p = -32768;
    if (m == 2 && p < 0) p = 0;
    return DW'(p);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send_word(input int w);
    pi_param_valid = 1'b1;
    pi_param = DW'(w);
    tick();
    pi_param_valid = 1'b0;
  endtask

  task automatic load_params(input int a, input int s, input int first);
    for (int k = first; k < 2 * CH; k++) begin
      send_word((k % 2 == 1) ? s : a);
      if (k % 2 == 1) std_m[k/2] = s;
      else            avg_m[k/2] = a;
      check("params_ready_load", params_ready, (k == 2 * CH - 1));
      if (k == 3) tick();
    end
    tick();
  endtask

  task automatic send_sample(input int m, input bit acc, input bit last);
    exp_t e;
    for (int c = 0; c < CH; c++) pi_data[c*DW +: DW] = DW'(xv[c]);
    mode = 2'(m);
    pi_data_valid = 1'b1;
    tick();
    pi_data_valid = 1'b0;
    if (acc) begin
      for (int c = 0; c < CH; c++) e.data[c*DW +: DW] = ref_norm(xv[c], avg_m[c], std_m[c], m);
      e.due = cyc + 3;
      e.last = last;
      sb.push_back(e);
    end
  endtask

  task automatic run_frame(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CH; c++) xv[c] = fx[i][c];
      send_sample(fm[i], 1'b1, i == n - 1);
      if (i == 0) check("busy_run", busy, 1);
      if (i < n - 1 && $urandom_range(0, 2) == 0) tick();
    end
    for (int c = 0; c < CH; c++) xv[c] = 1234;
    send_sample(1, 1'b0, 1'b0);  // lands in DONE
  endtask

  task automatic drain();
    repeat (6) tick();
  endtask

  always @(negedge sys_clk) begin
    if (po_data_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", po_data_valid, 0);
      end else begin
        mon_e = sb.pop_front();
        check("po_data", po_data, mon_e.data);
        check("latency", 64'(cyc), 64'(mon_e.due));
        check("frame_done", frame_done, mon_e.last);
        $display("out cyc=%0d data=%h frame_done=%b", cyc, po_data, frame_done);
      end
      if (frame_done) fd_count++;
    end else begin
      check("frame_done_idle", frame_done, 0);
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_valid", po_data_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < CH; c++) fx[i][c] = int'($urandom_range(0, 65535)) - 32768;
      fm[i] = (i < 4) ? 1 : i % 4;
    end
    for (int c = 0; c < CH; c++) begin
      fx[0][c] = 300; fx[1][c] = 100; fx[2][c] = 0; fx[3][c] = -100;
      fx[5][c] = 50;  fx[6][c] = 50;
    end
    fm[4] = 0; fm[5] = 1; fm[6] = 2; fm[7] = 1;
    fx[7][0] = -32768; fx[7][1] = 32767;

    sys_rst_n = 1'b0;
    repeat (3) tick();
    check("rst_po_data", po_data, 0);
    check("rst_valid", po_data_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_params_ready", params_ready, 0);
    check("rst_busy", busy, 0);
    sys_rst_n = 1'b1;
    tick();

    for (int c = 0; c < CH; c++) xv[c] = 7;
    send_sample(1, 1'b0, 1'b0);  // IDLE: dropped
    load_params(100, 'h200, 0);

    image_size = 9'd4;
    run_frame(16);
    drain();
    check("fd_frame1", fd_count, 1);
    check("busy_idle", busy, 0);
    run_frame(16);
    drain();
    check("fd_frame2", fd_count, 2);

    load_params(0, 'h100, 0);
    image_size = 9'd2;
    run_frame(4);
    drain();
    check("fd_frame3", fd_count, 3);

    // Parameter word and sample together in WAIT: the load wins.
    pi_param_valid = 1'b1;
    pi_param = '0;
    pi_data_valid = 1'b1;
    pi_data = {CH{16'h0055}};
    tick();
    pi_param_valid = 1'b0;
    pi_data_valid = 1'b0;
    avg_m[0] = 0;
    check("ready_collision", params_ready, 0);
    load_params(0, 'h100, 1);
    image_size = 9'd1;
    run_frame(1);
    image_size = 9'd0;
    run_frame(1);
    drain();
    check("fd_single", fd_count, 5);

    image_size = 9'd4;
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < CH; c++) xv[c] = fx[i][c];
      send_sample(fm[i], 1'b1, 1'b0);
    end
    sys_rst_n = 1'b0;
    tick();
    sb.delete();
    check("mid_rst_po_data", po_data, 0);
    check("mid_rst_valid", po_data_valid, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_params_ready", params_ready, 0);
    check("mid_rst_busy", busy, 0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    for (int c = 0; c < CH; c++) xv[c] = 99;
    send_sample(1, 1'b0, 1'b0);  // IDLE after reset: dropped
    drain();
    check("fd_after_rst", fd_count, 5);
    check("ready_after_rst", params_ready, 0);

    load_params(100, 'h200, 0);
    image_size = 9'd1;
    run_frame(1);
    drain();
    check("fd_reloaded", fd_count, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
